// File: rtl/vt_command_sequencer_pkg.sv
// Shared types and constants for the terminal command sequencer: parser command
// codes, parameter bundle, screen geometry and the erase fill character.
package vt_command_sequencer_pkg;

    localparam int         CONSOLE_LINES   = 24;
    localparam int         CONSOLE_COLUMNS = 80;
    localparam logic [7:0] ERASE_CHAR      = 8'h20;

    typedef enum logic [4:0] {
        INPUT, INIT_PN, EMIT_PN, IND, NEL, RI,
        CUU, CUD, CUF, CUB, CUP, EL, ED,
        SGR, SGR0, DECSTBM, DECSC, DECRC, SETMODE, RESETMODE,
        SCS0, SCS1, SS2, SS3, DCH, IL, DL
    } CommandsType;

    typedef struct packed {
        logic [7:0] Pchar;
        logic [7:0] Pn1;
        logic [7:0] Pn2;
        logic [1:0] Pns;
    } Param_t;

    typedef struct packed {
        CommandsType cmd;
        Param_t      param;
    } cmd_entry_t;

endpackage

// File: rtl/vt_command_sequencer_command_fifo.sv
// Small synchronous FIFO for parser commands. Head is read straight from the
// storage flops; a push into a full queue is accepted only when a pop frees a slot.
module command_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             dropped
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]                 cnt_q, cnt_d;
    logic                        do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign head    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vt_command_sequencer.sv
// Executes queued parser commands: tracks the cursor and turns each command into
// single-cycle text-RAM writes, including multi-cycle erase sweeps.
module vt_command_sequencer
    import vt_command_sequencer_pkg::*;
#(
    parameter int COLS       = CONSOLE_COLUMNS,
    parameter int LINES      = CONSOLE_LINES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          commandReady,
    input  CommandsType                   commandType,
    input  Param_t                        param,
    output logic                          ramWe,
    output logic [$clog2(COLS*LINES)-1:0] ramAddr,
    output logic [7:0]                    ramData,
    output logic [$clog2(LINES)-1:0]      cursorRow,
    output logic [$clog2(COLS)-1:0]       cursorCol,
    output logic                          scrollReq,
    output logic                          busy,
    output logic                          overflow
);

    localparam int          AW        = $clog2(COLS*LINES);
    localparam int          RW        = $clog2(LINES);
    localparam int          CW        = $clog2(COLS);
    localparam int          EW        = $bits(cmd_entry_t);
    localparam logic [15:0] LAST_ROW  = 16'(LINES-1);
    localparam logic [15:0] LAST_COL  = 16'(COLS-1);
    localparam logic [15:0] LAST_CELL = 16'(COLS*LINES-1);

    typedef enum logic {IDLE, ERASE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          we_q, we_d, scroll_q, scroll_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [AW-1:0] addr_q, addr_d, eptr_q, eptr_d, eend_q, eend_d;
    logic [7:0]    data_q, data_d;

    logic          pop, fifo_empty, fifo_full, fifo_dropped, lf;
    logic [EW-1:0] head_bits;
    cmd_entry_t    head;
    logic          unused_pns;

    command_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (commandReady),
        .push_data(EW'({commandType, param})),
        .pop      (pop),
        .head     (head_bits),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .dropped  (fifo_dropped)
    );

    assign head       = cmd_entry_t'(head_bits);
    assign unused_pns = ^{head.param.Pns, fifo_full};

    // All cursor arithmetic runs at 16 bits so Pn values up to 255 clamp correctly.
    logic [15:0] row_w, col_w, pn1, pn2, n, row_up, row_dn, col_lt, col_rt;
    logic [15:0] cup_row, cup_col, row_base, cur_cell, erase_lo, erase_hi;
    logic        erase_ok;

    always_comb begin
        row_w    = 16'(row_q);
        col_w    = 16'(col_q);
        pn1      = {8'd0, head.param.Pn1};
        pn2      = {8'd0, head.param.Pn2};
        n        = (pn1 == 16'd0) ? 16'd1 : pn1;
        row_up   = (n > row_w) ? 16'd0 : row_w - n;
        row_dn   = (row_w + n > LAST_ROW) ? LAST_ROW : row_w + n;
        col_lt   = (n > col_w) ? 16'd0 : col_w - n;
        col_rt   = (col_w + n > LAST_COL) ? LAST_COL : col_w + n;
        cup_row  = (pn1 == 16'd0) ? 16'd0 : ((pn1 > LAST_ROW) ? LAST_ROW : pn1 - 16'd1);
        cup_col  = (pn2 == 16'd0) ? 16'd0 : ((pn2 > LAST_COL) ? LAST_COL : pn2 - 16'd1);
        row_base = row_w * 16'(COLS);
        cur_cell = row_base + col_w;
        erase_ok = 1'b1;
        erase_lo = 16'd0;
        erase_hi = 16'd0;
        if (head.cmd == ED) begin
            case (pn1)
                16'd0:   begin erase_lo = cur_cell; erase_hi = LAST_CELL; end
                16'd1:   begin erase_lo = 16'd0;    erase_hi = cur_cell;  end
                16'd2:   begin erase_lo = 16'd0;    erase_hi = LAST_CELL; end
                default: erase_ok = 1'b0;
            endcase
        end else begin
            case (pn1)
                16'd0:   begin erase_lo = cur_cell; erase_hi = row_base + LAST_COL; end
                16'd1:   begin erase_lo = row_base; erase_hi = cur_cell;            end
                16'd2:   begin erase_lo = row_base; erase_hi = row_base + LAST_COL; end
                default: erase_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        we_d     = 1'b0;
        scroll_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        eptr_d   = eptr_q;
        eend_d   = eend_q;
        pop      = 1'b0;
        lf       = 1'b0;
        busy_d   = !fifo_empty || (state_q != IDLE);
        ovf_d    = ovf_q | fifo_dropped;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head.cmd)
                        INPUT: begin
                            if (head.param.Pchar >= 8'h20 && head.param.Pchar <= 8'h7E) begin
                                we_d   = 1'b1;
                                addr_d = AW'(cur_cell);
                                data_d = head.param.Pchar;
                                if (col_w == LAST_COL) begin
                                    col_d = '0;
                                    lf    = 1'b1;
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end else if (head.param.Pchar == 8'h0D) begin
                                col_d = '0;
                            end else if (head.param.Pchar == 8'h0A) begin
                                lf = 1'b1;
                            end else if (head.param.Pchar == 8'h08) begin
                                col_d = CW'(col_lt);
                            end
                        end
                        IND: lf = 1'b1;
                        NEL: begin
                            col_d = '0;
                            lf    = 1'b1;
                        end
                        RI:  row_d = (row_q == '0) ? '0 : row_q - RW'(1);
                        CUU: row_d = RW'(row_up);
                        CUD: row_d = RW'(row_dn);
                        CUF: col_d = CW'(col_rt);
                        CUB: col_d = CW'(col_lt);
                        CUP: begin
                            row_d = RW'(cup_row);
                            col_d = CW'(cup_col);
                        end
                        EL, ED: begin
                            if (erase_ok) begin
                                state_d = ERASE;
                                eptr_d  = AW'(erase_lo);
                                eend_d  = AW'(erase_hi);
                            end
                        end
                        default: ;
                    endcase
                    if (lf) begin
                        if (row_w == LAST_ROW) scroll_d = 1'b1;
                        else                   row_d    = row_q + RW'(1);
                    end
                end
            end
            ERASE: begin
                we_d   = 1'b1;
                addr_d = eptr_q;
                data_d = ERASE_CHAR;
                if (eptr_q == eend_q) state_d = IDLE;
                else                  eptr_d  = eptr_q + AW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            we_q     <= 1'b0;
            scroll_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= ERASE_CHAR;
            eptr_q   <= '0;
            eend_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            we_q     <= we_d;
            scroll_q <= scroll_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            eptr_q   <= eptr_d;
            eend_q   <= eend_d;
        end
    end

    assign ramWe     = we_q;
    assign ramAddr   = addr_q;
    assign ramData   = data_q;
    assign cursorRow = row_q;
    assign cursorCol = col_q;
    assign scrollReq = scroll_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_vt_command_sequencer.sv
// Directed bench for vt_command_sequencer: a vector table of single commands with
// hand-computed results, then hand-written erase, overflow and reset sequences.
module tb_vt_command_sequencer;
    import vt_command_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        commandReady;
    CommandsType commandType;
    Param_t      param;
    logic        ramWe, scrollReq, busy, overflow;
    logic [10:0] ramAddr;
    logic [7:0]  ramData;
    logic [4:0]  cursorRow;
    logic [6:0]  cursorCol;

    always #5 clk = ~clk;

    vt_command_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .commandReady(commandReady),
        .commandType (commandType),
        .param       (param),
        .ramWe       (ramWe),
        .ramAddr     (ramAddr),
        .ramData     (ramData),
        .cursorRow   (cursorRow),
        .cursorCol   (cursorCol),
        .scrollReq   (scrollReq),
        .busy        (busy),
        .overflow    (overflow)
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;
    wr_t wlog[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ramWe) wlog.push_back('{cyc: cyc, addr: int'(ramAddr), data: int'(ramData)});

    typedef struct {
        string       name;
        CommandsType cmd;
        logic [7:0]  pc, p1, p2;
        logic        we;
        int          addr, data, row, col;
        logic        scroll;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(string nm, CommandsType c, logic [7:0] pc, logic [7:0] p1, logic [7:0] p2,
                                logic we, int addr, int data, int row, int col, logic sc);
        vec_t v;
        v.name = nm; v.cmd = c; v.pc = pc; v.p1 = p1; v.p2 = p2;
        v.we = we; v.addr = addr; v.data = data; v.row = row; v.col = col; v.scroll = sc;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(CommandsType c, logic [7:0] pc, logic [7:0] p1, logic [7:0] p2);
        @(negedge clk);
        commandReady = 1'b1;
        commandType  = c;
        param        = '{Pchar: pc, Pn1: p1, Pn2: p2, Pns: 2'd0};
        @(negedge clk);
        commandReady = 1'b0;
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(n < bound), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        rst          = 1'b1;
        commandReady = 1'b0;
        commandType  = INPUT;
        param        = '0;

        // Row/col/addr/data expectations are worked by hand from the cursor path.
        vecs.push_back(mk("print_A",     INPUT, 8'h41, 0,   0,   1, 0,    8'h41, 0,  1,  0));
        vecs.push_back(mk("bs",          INPUT, 8'h08, 0,   0,   0, 0,    0,     0,  0,  0));
        vecs.push_back(mk("bs_clamp",    INPUT, 8'h08, 0,   0,   0, 0,    0,     0,  0,  0));
        vecs.push_back(mk("cup_max",     CUP,   0,     24,  80,  0, 0,    0,     23, 79, 0));
        vecs.push_back(mk("print_wrap",  INPUT, 8'h78, 0,   0,   1, 1919, 8'h78, 23, 0,  1));
        vecs.push_back(mk("cup_zero",    CUP,   0,     0,   0,   0, 0,    0,     0,  0,  0));
        vecs.push_back(mk("cuf_200",     CUF,   0,     200, 0,   0, 0,    0,     0,  79, 0));
        vecs.push_back(mk("cuu_top",     CUU,   0,     0,   0,   0, 0,    0,     0,  79, 0));
        vecs.push_back(mk("cud_dflt",    CUD,   0,     0,   0,   0, 0,    0,     1,  79, 0));
        vecs.push_back(mk("cud_255",     CUD,   0,     255, 0,   0, 0,    0,     23, 79, 0));
        vecs.push_back(mk("cub_5",       CUB,   0,     5,   0,   0, 0,    0,     23, 74, 0));
        vecs.push_back(mk("cuu_3",       CUU,   0,     3,   0,   0, 0,    0,     20, 74, 0));
        vecs.push_back(mk("cr",          INPUT, 8'h0D, 0,   0,   0, 0,    0,     20, 0,  0));
        vecs.push_back(mk("lf",          INPUT, 8'h0A, 0,   0,   0, 0,    0,     21, 0,  0));
        vecs.push_back(mk("ri",          RI,    0,     0,   0,   0, 0,    0,     20, 0,  0));
        vecs.push_back(mk("ind",         IND,   0,     0,   0,   0, 0,    0,     21, 0,  0));
        vecs.push_back(mk("cup_3_10",    CUP,   0,     3,   10,  0, 0,    0,     2,  9,  0));
        vecs.push_back(mk("print_k",     INPUT, 8'h6B, 0,   0,   1, 169,  8'h6B, 2,  10, 0));
        vecs.push_back(mk("nel",         NEL,   0,     0,   0,   0, 0,    0,     3,  0,  0));
        vecs.push_back(mk("bell_ign",    INPUT, 8'h07, 0,   0,   0, 0,    0,     3,  0,  0));
        vecs.push_back(mk("sgr_nop",     SGR,   0,     1,   0,   0, 0,    0,     3,  0,  0));
        vecs.push_back(mk("cup_24_5",    CUP,   0,     24,  5,   0, 0,    0,     23, 4,  0));
        vecs.push_back(mk("nel_bottom",  NEL,   0,     0,   0,   0, 0,    0,     23, 0,  1));
        vecs.push_back(mk("print_z",     INPUT, 8'h7A, 0,   0,   1, 1840, 8'h7A, 23, 1,  0));
        vecs.push_back(mk("cub_255",     CUB,   0,     255, 0,   0, 0,    0,     23, 0,  0));
        vecs.push_back(mk("cup_255",     CUP,   0,     255, 255, 0, 0,    0,     23, 79, 0));
        vecs.push_back(mk("el_bad",      EL,    0,     3,   0,   0, 0,    0,     23, 79, 0));
        vecs.push_back(mk("ed_bad",      ED,    0,     9,   0,   0, 0,    0,     23, 79, 0));
        vecs.push_back(mk("cup_home",    CUP,   0,     1,   1,   0, 0,    0,     0,  0,  0));
        vecs.push_back(mk("ri_top",      RI,    0,     0,   0,   0, 0,    0,     0,  0,  0));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_we",     ramWe,     0);
        check("rst_addr",   ramAddr,   0);
        check("rst_data",   ramData,   8'h20);
        check("rst_row",    cursorRow, 0);
        check("rst_col",    cursorCol, 0);
        check("rst_scroll", scrollReq, 0);
        check("rst_busy",   busy,      0);
        check("rst_ovf",    overflow,  0);

        foreach (vecs[i]) begin
            send(vecs[i].cmd, vecs[i].pc, vecs[i].p1, vecs[i].p2);
            @(negedge clk);
            check({vecs[i].name, "_we"},     ramWe,     vecs[i].we);
            check({vecs[i].name, "_row"},    cursorRow, vecs[i].row);
            check({vecs[i].name, "_col"},    cursorCol, vecs[i].col);
            check({vecs[i].name, "_scroll"}, scrollReq, vecs[i].scroll);
            check({vecs[i].name, "_busy"},   busy,      1);
            if (vecs[i].we) begin
                check({vecs[i].name, "_addr"}, ramAddr, vecs[i].addr);
                check({vecs[i].name, "_data"}, ramData, vecs[i].data);
            end
            @(negedge clk);
            check({vecs[i].name, "_we_off"},     ramWe,     0);
            check({vecs[i].name, "_scroll_off"}, scrollReq, 0);
            check({vecs[i].name, "_busy_off"},   busy,      0);
        end

        // Erase to end of line from (2,77): three consecutive fills.
        send(CUP, 0, 3, 78);
        wait_idle(20);
        wlog.delete();
        send(EL, 0, 0, 0);
        wait_idle(20);
        check("el_writes", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            check("el_addr", wlog[i].addr, 237 + i);
            check("el_data", wlog[i].data, 8'h20);
            check("el_consec", wlog[i].cyc - wlog[0].cyc, i);
        end
        check("el_row", cursorRow, 2);
        check("el_col", cursorCol, 77);

        // Full-screen erase with three characters queued behind it.
        send(CUP, 0, 1, 1);
        wait_idle(20);
        wlog.delete();
        send(ED, 0, 2, 0);
        repeat (3) @(negedge clk);
        send(INPUT, 8'h61, 0, 0);
        send(INPUT, 8'h62, 0, 0);
        send(INPUT, 8'h63, 0, 0);
        wait_idle(5000);
        check("ed_writes", wlog.size(), 1923);
        bad = 0;
        for (int i = 0; i < 1920 && i < wlog.size(); i++)
            if (wlog[i].addr != i || wlog[i].data != 8'h20) bad++;
        check("ed_erase_cells_bad", bad, 0);
        for (int i = 0; i < 3 && 1920 + i < wlog.size(); i++) begin
            check("ed_chr_addr", wlog[1920+i].addr, i);
            check("ed_chr_data", wlog[1920+i].data, 8'h61 + i);
        end
        check("ed_col", cursorCol, 3);
        check("ed_ovf", overflow, 0);

        // Five back-to-back pushes while erasing: the fifth is dropped.
        wlog.delete();
        send(ED, 0, 2, 0);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            commandReady = 1'b1;
            commandType  = INPUT;
            param        = '{Pchar: 8'(8'h70 + j), Pn1: 8'd0, Pn2: 8'd0, Pns: 2'd0};
        end
        @(negedge clk);
        commandReady = 1'b0;
        check("ovf_set", overflow, 1);
        wait_idle(5000);
        check("ovf_writes", wlog.size(), 1924);
        for (int i = 0; i < 4 && 1920 + i < wlog.size(); i++) begin
            check("ovf_chr_addr", wlog[1920+i].addr, 3 + i);
            check("ovf_chr_data", wlog[1920+i].data, 8'h70 + i);
        end
        check("ovf_col", cursorCol, 7);
        check("ovf_sticky", overflow, 1);

        // Reset in the middle of an erase with a command still queued.
        send(ED, 0, 2, 0);
        send(INPUT, 8'h51, 0, 0);
        repeat (50) @(negedge clk);
        check("mid_erase_we", ramWe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_we",     ramWe,     0);
        check("abort_addr",   ramAddr,   0);
        check("abort_data",   ramData,   8'h20);
        check("abort_row",    cursorRow, 0);
        check("abort_col",    cursorCol, 0);
        check("abort_scroll", scrollReq, 0);
        check("abort_busy",   busy,      0);
        check("abort_ovf",    overflow,  0);
        wlog.delete();
        repeat (2200) @(negedge clk);
        check("abort_no_writes", wlog.size(), 0);
        check("abort_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
